// File: rtl/seq_divider_pkg.sv
// Shared types and sizing for the seq_divider restoring divider (package div_pkg).
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 32;

   // Counter must hold the value WIDTH itself, hence width+1.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

   localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done bundle between ALU control and seq_divider.
// Optional macro SEQ_DIVIDER_SIGNED_EN adds the signed_mode request bit.
interface seq_divider_if #(parameter int WIDTH = div_pkg::DEFAULT_WIDTH);
   import div_pkg::*;

   // start is sampled only while busy=0 and not in the DONE cycle; operands are
   // captured on that same edge. done pulses once when results update, and the
   // results then hold until the next completion.
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
   logic             signed_mode;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   state_t           state;

`ifdef SEQ_DIVIDER_SIGNED_EN
   modport master (
      output start, dividend, divisor, signed_mode,
      input  busy, done, quotient, remainder, div_by_zero, state
   );
   modport slave (
      input  start, dividend, divisor, signed_mode,
      output busy, done, quotient, remainder, div_by_zero, state
   );
`else
   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero, state
   );
   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero, state
   );
`endif

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: subtract with borrow, restore on borrow.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // Keep the full WIDTH+1 shifted value so divisors with the MSB set still work.
   assign shifted = {rem_in, bit_in};
   assign diff    = shifted - {1'b0, divisor};
   assign q_bit   = ~diff[WIDTH];
   assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, start/busy/done control.
// Optional macro SEQ_DIVIDER_SIGNED_EN enables two's-complement division via signed_mode.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic         clk,
   input  logic         reset_n,
   seq_divider_if.slave bus
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] dvs_q;
   logic             dbz_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rem_q;
   logic             dbz_out_q;
   logic [WIDTH-1:0] step_rem;
   logic             step_bit;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic a_neg;
   logic b_neg;
   logic neg_quo_q;
   logic neg_rem_q;

   // The unsigned core only ever sees magnitudes; signs are reapplied in DONE.
   always_comb begin
      a_neg = bus.signed_mode & bus.dividend[WIDTH-1];
      b_neg = bus.signed_mode & bus.divisor[WIDTH-1];
      a_mag = a_neg ? -bus.dividend : bus.dividend;
      b_mag = b_neg ? -bus.divisor  : bus.divisor;
   end
`else
   assign a_mag = bus.dividend;
   assign b_mag = bus.divisor;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (r_q),
      .bit_in  (q_q[WIDTH-1]),
      .divisor (dvs_q),
      .rem_out (step_rem),
      .q_bit   (step_bit)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         r_q       <= '0;
         q_q       <= '0;
         dvs_q     <= '0;
         dbz_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         quo_q     <= '0;
         rem_q     <= '0;
         dbz_out_q <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.start) begin
                  dbz_q  <= (bus.divisor == '0);
                  r_q    <= '0;
                  // Divide-by-zero keeps the raw dividend so it can be returned as remainder.
                  q_q    <= (bus.divisor == '0) ? bus.dividend : a_mag;
                  dvs_q  <= b_mag;
                  cnt_q  <= CW'(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
                  neg_quo_q <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
`endif
                  if (bus.divisor == '0) begin
                     state_q <= DONE;
                  end else begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                  end
               end
            end
            RUN: begin
               r_q   <= step_rem;
               q_q   <= {q_q[WIDTH-2:0], step_bit};
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b1;
               if (dbz_q) begin
                  quo_q     <= '1;
                  rem_q     <= q_q;
                  dbz_out_q <= 1'b1;
               end else begin
                  dbz_out_q <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                  quo_q <= neg_quo_q ? -q_q : q_q;
                  rem_q <= neg_rem_q ? -r_q : r_q;
`else
                  quo_q <= q_q;
                  rem_q <= r_q;
`endif
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quo_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_out_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random operands
// scored against an arithmetic model. Honours SEQ_DIVIDER_SIGNED_EN when defined.
module tb_seq_divider;
   import div_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   seq_divider_if #(.WIDTH(W)) bus ();

   seq_divider #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] last_q = '0;
   logic [W-1:0] last_r = '0;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division, truncating toward zero in signed mode.
   task automatic model_push(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic [W-1:0] z;
      longint sa;
      longint sb;
      if (b == '0) begin
         q = '1;
         r = a;
         z = 1;
      end else if (sm) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q = W'(sa / sb);
         r = W'(sa % sb);
         z = 0;
      end else begin
         q = a / b;
         r = a % b;
         z = 0;
      end
      exp_q.push_back(q);
      exp_q.push_back(r);
      exp_q.push_back(z);
   endtask

   task automatic drive_sm(input logic sm);
`ifdef SEQ_DIVIDER_SIGNED_EN
      bus.signed_mode = sm;
`else
      if (sm) $display("note: signed request in unsigned build");
`endif
   endtask

   // Called at a negedge; returns at the negedge where done is seen.
   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                          input int intrude_at);
      int lat;
      int busy_cnt;
      logic got;
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic [W-1:0] ez;
      model_push(a, b, sm);
      bus.dividend = a;
      bus.divisor  = b;
      drive_sm(sm);
      bus.start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start    = 1'b0;
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
      busy_cnt = 0;
      lat = 0;
      got = 1'b0;
      for (int k = 1; k <= W + 10 && !got; k++) begin
         if (bus.busy) busy_cnt++;
         if (k == 5) begin
            check("hold_quotient", bus.quotient, last_q);
            check("hold_remainder", bus.remainder, last_r);
         end
         if (intrude_at > 0 && (k == intrude_at || k == W + 1)) begin
            bus.start    = 1'b1;
            bus.dividend = $urandom;
            bus.divisor  = $urandom_range(1, 9);
         end
         @(posedge clk);
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done) begin
            got = 1'b1;
            lat = k;
         end
      end
      eq = exp_q.pop_front();
      er = exp_q.pop_front();
      ez = exp_q.pop_front();
      check("done_seen", W'(got), 1);
      check("latency", lat, (b == '0) ? 1 : W + 1);
      check("busy_cycles", busy_cnt, (b == '0) ? 0 : W);
      if (got) begin
         check("quotient", bus.quotient, eq);
         check("remainder", bus.remainder, er);
         check("div_by_zero", W'(bus.div_by_zero), ez);
         last_q = eq;
         last_r = er;
      end
      if (intrude_at > 0) begin
         @(posedge clk);
         @(negedge clk);
         check("done_one_cycle", W'(bus.done), 0);
         check("no_queued_start", W'(bus.busy), 0);
      end
   endtask

   task automatic abort_run();
      logic seen;
      bus.dividend = 100;
      bus.divisor  = 7;
      drive_sm(1'b0);
      bus.start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (19) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("abort_busy_before", W'(bus.busy), 1);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_busy", W'(bus.busy), 0);
      check("abort_quotient", bus.quotient, 0);
      check("abort_remainder", bus.remainder, 0);
      check("abort_dbz", W'(bus.div_by_zero), 0);
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      check("abort_no_done", W'(seen), 0);
      last_q = '0;
      last_r = '0;
   endtask

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic sm;
      int sel;

      // Reset with a start request pending; it must not be taken.
      bus.start    = 1'b1;
      bus.dividend = 32'd55;
      bus.divisor  = 32'd3;
      drive_sm(1'b0);
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_busy", W'(bus.busy), 0);
      check("rst_done", W'(bus.done), 0);
      check("rst_quotient", bus.quotient, 0);
      check("rst_remainder", bus.remainder, 0);
      check("rst_dbz", W'(bus.div_by_zero), 0);
      check("rst_state", W'(bus.state), W'(IDLE));

      run_div(32'd100, 32'd7, 1'b0, 0);
      run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
      run_div(32'd5, 32'd9, 1'b0, 0);
      run_div(32'h0000_1234, 32'd0, 1'b0, 0);
      run_div(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 0);
      run_div(32'd1000, 32'd33, 1'b0, 10);
      abort_run();

`ifdef SEQ_DIVIDER_SIGNED_EN
      run_div(-32'sd7, 32'd2, 1'b1, 0);
      run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
      run_div(32'd7, -32'sd2, 1'b1, 0);
      run_div(-32'sd9, 32'd0, 1'b1, 0);
`endif

      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0)      b = '0;
         else if (sel <= 3) b = $urandom_range(1, 255);
         else if (sel <= 5) b = $urandom | 32'h8000_0000;
         else               b = $urandom;
         a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
`ifdef SEQ_DIVIDER_SIGNED_EN
         sm = 1'($urandom_range(0, 1));
`else
         sm = 1'b0;
`endif
         run_div(a, b, sm, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
